calc1_engine: RTL and testbench

Four-port integer calculator. Each requester issues a two-cycle request on its own port: command plus operand1, then operand2. The block returns a response code and a 32-bit result on that port's output after a fixed latency. It sits between four independent requesters and has no shared arbitration; the four ports are fully parallel.

---
 rtl/calc1_engine.sv | 162 ++++++++++++++++
 tb/tb_calc1_engine.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/calc1_engine.sv
// calc1_engine: four independent two-cycle request ports, each with its own
// add/sub/shift unit and a fixed-latency registered response pipeline.
// Optional feature macro: CALC1_SHIFT_EN (enables commands 5/6 as shifts).
// Vectors at the ports are big-endian: bit 0 is the MSB.

// One request port: request FSM, operand latch, ALU and response pipeline.
module calc1_port #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [0:3]        cmd,
  input  logic [0:DATA_W-1] data,
  output logic [0:DATA_W-1] out_data,
  output logic [0:1]        out_resp
);

  localparam int unsigned SH_W     = 5;
  localparam logic [1:0]  RESP_OK  = 2'd1;
  localparam logic [1:0]  RESP_ERR = 2'd2;

  typedef enum logic {ST_IDLE, ST_OP2} state_t;

  typedef struct packed {
    logic [1:0]        resp;
    logic [DATA_W-1:0] data;
  } rsp_t;

  state_t            state, state_nxt;
  logic              launch_c;
  logic [3:0]        cmd_q;
  logic [DATA_W-1:0] op1_q;
  logic [DATA_W-1:0] op2_w;
  logic [DATA_W:0]   sum_c;
  rsp_t              res_c;
  rsp_t              pipe [0:LAT];

  // Internal arithmetic uses descending vectors; value order is unchanged.
  assign op2_w = data;

  // Request FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and launch strobe: operand2 cycle always launches.
  always_comb begin
    state_nxt = state;
    launch_c  = 1'b0;
    case (state)
      ST_IDLE: if (cmd != 4'd0) state_nxt = ST_OP2;
      ST_OP2: begin
        launch_c  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Capture command and operand1 in the first request cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= 4'd0;
      op1_q <= '0;
    end else if (state == ST_IDLE && cmd != 4'd0) begin
      cmd_q <= cmd;
      op1_q <= data;
    end
  end

  // ALU: unsigned add/sub with range errors, optional logical shifts.
  always_comb begin
    res_c = '0;
    sum_c = {1'b0, op1_q} + {1'b0, op2_w};
    case (cmd_q)
      4'd1: begin
        if (sum_c[DATA_W]) res_c.resp = RESP_ERR;
        else begin
          res_c.resp = RESP_OK;
          res_c.data = sum_c[DATA_W-1:0];
        end
      end
      4'd2: begin
        if (op2_w > op1_q) res_c.resp = RESP_ERR;
        else begin
          res_c.resp = RESP_OK;
          res_c.data = op1_q - op2_w;
        end
      end
`ifdef CALC1_SHIFT_EN
      4'd5: begin
        res_c.resp = RESP_OK;
        res_c.data = op1_q << op2_w[SH_W-1:0];
      end
      4'd6: begin
        res_c.resp = RESP_OK;
        res_c.data = op1_q >> op2_w[SH_W-1:0];
      end
`endif
      default: res_c.resp = RESP_ERR;
    endcase
  end

  // Response pipeline: stage 0 loads at the operand2 edge, stage LAT drives out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= int'(LAT); k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= launch_c ? res_c : '0;
      for (int k = 1; k <= int'(LAT); k++) pipe[k] <= pipe[k-1];
    end
  end

  assign out_data = pipe[LAT].data;
  assign out_resp = pipe[LAT].resp;

endmodule

// Top: four fully parallel ports sharing only clock and reset.
module calc1_engine #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LAT    = 2
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [0:3]        req1_cmd_in,
  input  logic [0:DATA_W-1] req1_data_in,
  input  logic [0:3]        req2_cmd_in,
  input  logic [0:DATA_W-1] req2_data_in,
  input  logic [0:3]        req3_cmd_in,
  input  logic [0:DATA_W-1] req3_data_in,
  input  logic [0:3]        req4_cmd_in,
  input  logic [0:DATA_W-1] req4_data_in,
  output logic [0:DATA_W-1] out_data1,
  output logic [0:1]        out_resp1,
  output logic [0:DATA_W-1] out_data2,
  output logic [0:1]        out_resp2,
  output logic [0:DATA_W-1] out_data3,
  output logic [0:1]        out_resp3,
  output logic [0:DATA_W-1] out_data4,
  output logic [0:1]        out_resp4
);

  calc1_port #(.DATA_W(DATA_W), .LAT(LAT)) u_port1 (
    .clk(c_clk), .rst_n(reset), .cmd(req1_cmd_in), .data(req1_data_in),
    .out_data(out_data1), .out_resp(out_resp1));

  calc1_port #(.DATA_W(DATA_W), .LAT(LAT)) u_port2 (
    .clk(c_clk), .rst_n(reset), .cmd(req2_cmd_in), .data(req2_data_in),
    .out_data(out_data2), .out_resp(out_resp2));

  calc1_port #(.DATA_W(DATA_W), .LAT(LAT)) u_port3 (
    .clk(c_clk), .rst_n(reset), .cmd(req3_cmd_in), .data(req3_data_in),
    .out_data(out_data3), .out_resp(out_resp3));

  calc1_port #(.DATA_W(DATA_W), .LAT(LAT)) u_port4 (
    .clk(c_clk), .rst_n(reset), .cmd(req4_cmd_in), .data(req4_data_in),
    .out_data(out_data4), .out_resp(out_resp4));

endmodule

// File: tb/tb_calc1_engine.sv
// Scoreboard bench for calc1_engine: expected responses are queued when a
// request's operand2 is driven and compared every cycle on every port.
module tb_calc1_engine;

  localparam int LAT = 2;

  typedef struct {
    int          port;
    int          due;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  logic        c_clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  cmd_d [4];
  logic [31:0] dat_d [4];
  logic [31:0] od    [4];
  logic [1:0]  orsp  [4];

  logic [3:0]  pend_cmd [4];
  logic [31:0] pend_a   [4];
  logic [31:0] pend_b   [4];

  exp_t sbq[$];
  int   cyc     = 0;
  int   n_checks = 0;
  int   n_err   = 0;

  calc1_engine #(.DATA_W(32), .LAT(LAT)) dut (
    .c_clk(c_clk), .reset(reset),
    .req1_cmd_in(cmd_d[0]), .req1_data_in(dat_d[0]),
    .req2_cmd_in(cmd_d[1]), .req2_data_in(dat_d[1]),
    .req3_cmd_in(cmd_d[2]), .req3_data_in(dat_d[2]),
    .req4_cmd_in(cmd_d[3]), .req4_data_in(dat_d[3]),
    .out_data1(od[0]), .out_resp1(orsp[0]),
    .out_data2(od[1]), .out_resp2(orsp[1]),
    .out_data3(od[2]), .out_resp3(orsp[2]),
    .out_data4(od[3]), .out_resp4(orsp[3]));

  always #5 c_clk = ~c_clk;

  always @(posedge c_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Reference behaviour: {resp, data}.
  function automatic logic [33:0] model(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [32:0] s;
    case (c)
      4'd1: begin
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? {2'd2, 32'd0} : {2'd1, s[31:0]};
      end
      4'd2: return (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
`ifdef CALC1_SHIFT_EN
      4'd5: return {2'd1, a << b[4:0]};
      4'd6: return {2'd1, a >> b[4:0]};
`endif
      default: return {2'd2, 32'd0};
    endcase
  endfunction

  // Compare every port on the falling edge; zero is expected unless due.
  always @(negedge c_clk) begin
    for (int p = 0; p < 4; p++) begin
      logic [1:0]  er;
      logic [31:0] ed;
      er = 2'd0;
      ed = 32'd0;
      for (int i = 0; i < sbq.size(); i++) begin
        if (sbq[i].port == p && sbq[i].due == cyc) begin
          er = sbq[i].resp;
          ed = sbq[i].data;
          sbq.delete(i);
          break;
        end
      end
      check($sformatf("resp%0d", p + 1), 32'(orsp[p]), 32'(er));
      check($sformatf("data%0d", p + 1), od[p], ed);
    end
  end

  task automatic clear_pend();
    for (int p = 0; p < 4; p++) begin
      pend_cmd[p] = 4'd0;
      pend_a[p]   = 32'd0;
      pend_b[p]   = 32'd0;
    end
  endtask

  // Issue the pending requests on all ports in parallel (two cycles).
  task automatic go();
    logic [33:0] m;
    exp_t        e;
    @(posedge c_clk); #1;
    for (int p = 0; p < 4; p++) begin
      cmd_d[p] = pend_cmd[p];
      dat_d[p] = pend_a[p];
    end
    @(posedge c_clk); #1;
    for (int p = 0; p < 4; p++) begin
      cmd_d[p] = 4'd0;
      dat_d[p] = pend_b[p];
      if (pend_cmd[p] != 4'd0) begin
        m      = model(pend_cmd[p], pend_a[p], pend_b[p]);
        e.port = p;
        e.due  = cyc + 1 + LAT;
        e.resp = m[33:32];
        e.data = m[31:0];
        sbq.push_back(e);
      end
    end
    clear_pend();
  endtask

  task automatic one(input int p, input logic [3:0] c, input logic [31:0] a,
                     input logic [31:0] b);
    pend_cmd[p] = c;
    pend_a[p]   = a;
    pend_b[p]   = b;
    go();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge c_clk); #1;
      for (int p = 0; p < 4; p++) begin
        cmd_d[p] = 4'd0;
        dat_d[p] = 32'd0;
      end
    end
  endtask

  initial begin
    for (int p = 0; p < 4; p++) begin
      cmd_d[p] = 4'd0;
      dat_d[p] = 32'd0;
    end
    clear_pend();
    // Reset held low with live stimulus; outputs must stay zero.
    repeat (4) begin
      @(posedge c_clk); #1;
      cmd_d[0] = 4'd1;
      dat_d[0] = 32'hFFFF_0000;
    end
    cmd_d[0] = 4'd0;
    dat_d[0] = 32'd0;
    reset = 1'b1;

    // Port1 adds, back to back.
    one(0, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF);
    one(0, 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF);
    one(0, 4'd1, 32'h0000_0000, 32'h0000_0000);
    // Overflow, underflow, equal and plain subtract.
    one(0, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001);
    one(0, 4'd2, 32'h0000_0001, 32'h0000_000F);
    one(0, 4'd2, 32'h1234_5678, 32'h1234_5678);
    one(0, 4'd2, 32'h0000_0010, 32'h0000_0003);
    // Invalid commands and shifts.
    one(0, 4'd3, 32'h0000_0005, 32'h0000_0006);
    one(0, 4'd4, 32'h0000_0005, 32'h0000_0006);
    one(0, 4'd5, 32'h0000_0001, 32'h0000_0024);
    one(0, 4'd6, 32'h8000_0000, 32'h0000_001F);
    one(0, 4'd15, 32'hDEAD_BEEF, 32'h0000_0001);
    idle(LAT + 2);

    // All four ports, different adds, back to back twice.
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 4; p++) begin
        pend_cmd[p] = 4'd1;
        pend_a[p]   = 32'h1000_0000 * (p + 1) + 32'(r);
        pend_b[p]   = 32'h0000_0101 * (p + 3) + 32'(r * 7);
      end
      go();
    end
    idle(LAT + 2);

    // Reset the cycle after a port2 command: request must vanish.
    @(posedge c_clk); #1;
    cmd_d[1] = 4'd1;
    dat_d[1] = 32'h0000_0005;
    @(posedge c_clk); #1;
    cmd_d[1] = 4'd0;
    dat_d[1] = 32'h0000_0007;
    reset    = 1'b0;
    @(posedge c_clk); #1;
    @(posedge c_clk); #1;
    reset = 1'b1;
    idle(LAT + 2);
    one(1, 4'd1, 32'h0000_0100, 32'h0000_0023);
    idle(LAT + 2);

    // Mixed random traffic on all ports.
    for (int i = 0; i < 24; i++) begin
      for (int p = 0; p < 4; p++) begin
        pend_cmd[p] = 4'($urandom_range(0, 7));
        pend_a[p]   = $urandom;
        pend_b[p]   = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 64));
      end
      go();
    end
    idle(LAT + 3);

    check("drain", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
